// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ==== seg_scan_decoder : rebuilds 4 BCD digits from a scanned 7-seg bus ====
// ==== Revision 1.0                                                      ====

module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_data,
  input  logic [3:0] AN,
  output logic [3:0] dig_0,
  output logic [3:0] dig_1,
  output logic [3:0] dig_2,
  output logic [3:0] dig_3,
  output logic       frame_valid,
  output logic       bad_seg,
  output logic       stale
);

  localparam int C_CW = $clog2(SETTLE_CYCLES + 1);
  localparam int C_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CW-1:0] C_SETTLE_MAX  = C_CW'(SETTLE_CYCLES);
  localparam logic [C_CW-1:0] C_SETTLE_PRE  = C_CW'(SETTLE_CYCLES - 1);
  localparam logic [C_TW-1:0] C_TIMEOUT_MAX = C_TW'(TIMEOUT_CYCLES);

  logic [6:0]      s_seg_q, s_seg_d;
  logic [3:0]      s_an_q, s_an_d;
  logic [C_CW-1:0] stab_q, stab_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic            fv_q, fv_d;
  logic            bad_q, bad_d;
  logic [C_TW-1:0] tcnt_q, tcnt_d;

  logic            w_same;
  logic            w_an_ok;
  logic            w_capture;
  logic [1:0]      w_cap_idx;
  logic [3:0]      w_cap_val;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:        seg_decode = 4'd0;
      7'h79:        seg_decode = 4'd1;
      7'h24:        seg_decode = 4'd2;
      7'h30:        seg_decode = 4'd3;
      7'h19:        seg_decode = 4'd4;
      7'h12:        seg_decode = 4'd5;
      7'h02:        seg_decode = 4'd6;
      7'h78:        seg_decode = 4'd7;
      7'h00:        seg_decode = 4'd8;
      7'h10, 7'h18: seg_decode = 4'd9;
      7'h7F:        seg_decode = 4'hF;
      default:      seg_decode = 4'hE;
    endcase
  endfunction

  always_comb begin
    s_seg_d = seg_data;
    s_an_d  = AN;

    // The counter value after an edge is the run length of identical samples
    // ending with the sample taken at that edge, so the incoming sample is
    // compared against the current registered one.
    w_same  = ({AN, seg_data} == {s_an_q, s_seg_q});
    if (!w_same) begin
      stab_d = C_CW'(1);
    end else if (stab_q == C_SETTLE_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + C_CW'(1);
    end

    w_an_ok   = $onehot(~s_an_q);
    w_capture = w_same && (stab_q == C_SETTLE_PRE) && w_an_ok;
    w_cap_val = seg_decode(s_seg_q);
    w_cap_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!s_an_q[i]) w_cap_idx = 2'(i);
    end

    shadow_d = shadow_q;
    mask_d   = mask_q;
    dig_d    = dig_q;
    fv_d     = 1'b0;
    bad_d    = bad_q;

    if (w_capture) begin
      shadow_d[w_cap_idx] = w_cap_val;
      mask_d[w_cap_idx]   = 1'b1;
      if (w_cap_val == 4'hE) bad_d = 1'b1;
      if (mask_d == 4'hF) begin
        dig_d  = shadow_d;
        fv_d   = 1'b1;
        mask_d = 4'h0;
      end
    end

    if (fv_d) begin
      tcnt_d = '0;
    end else if (tcnt_q == C_TIMEOUT_MAX) begin
      tcnt_d = tcnt_q;
    end else begin
      tcnt_d = tcnt_q + C_TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q  <= 7'h7F;
      s_an_q   <= 4'hF;
      stab_q   <= '0;
      shadow_q <= {4{4'hF}};
      mask_q   <= 4'h0;
      dig_q    <= {4{4'hF}};
      fv_q     <= 1'b0;
      bad_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      s_seg_q  <= s_seg_d;
      s_an_q   <= s_an_d;
      stab_q   <= stab_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      dig_q    <= dig_d;
      fv_q     <= fv_d;
      bad_q    <= bad_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign dig_0       = dig_q[0];
  assign dig_1       = dig_q[1];
  assign dig_2       = dig_q[2];
  assign dig_3       = dig_q[3];
  assign frame_valid = fv_q;
  assign bad_seg     = bad_q;
  assign stale       = (tcnt_q == C_TIMEOUT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ==== tb_seg_scan_decoder : scoreboard bench for seg_scan_decoder ====
// ==== Revision 1.0                                                 ====

module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam int T = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_data = 7'h7F;
  logic [3:0] AN = 4'hF;
  logic [3:0] dig_0, dig_1, dig_2, dig_3;
  logic       frame_valid, bad_seg, stale;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .seg_data(seg_data), .AN(AN),
    .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2), .dig_3(dig_3),
    .frame_valid(frame_valid), .bad_seg(bad_seg), .stale(stale)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: sample run length, captured digits, frame history.
  logic [15:0] exp_q[$];
  int          run = 0;
  logic [10:0] last = '0;
  logic [3:0]  sh[4];
  logic [3:0]  mask = 4'h0;
  logic [15:0] hold = 16'hFFFF;
  bit          bad = 1'b0;
  bit          efv = 1'b0;
  int          since = 0;
  bit          mon_en = 1'b0;
  logic [6:0]  code[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [3:0] dec(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (s == code[d]) return 4'(d);
    if (s == 7'h18) return 4'd9;
    if (s == 7'h7F) return 4'hF;
    return 4'hE;
  endfunction

  task automatic model(input logic [3:0] an, input logic [6:0] seg, input bit r);
    int idx;
    logic [3:0] d;
    efv = 1'b0;
    if (r) begin
      run = 0; mask = 4'h0; hold = 16'hFFFF; bad = 1'b0; since = 0;
      for (int i = 0; i < 4; i++) sh[i] = 4'hF;
      return;
    end
    if (run > 0 && {an, seg} == last) run++;
    else run = 1;
    last = {an, seg};
    if (run == S && $countones(~an) == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
      d = dec(seg);
      sh[idx] = d;
      if (d == 4'hE) bad = 1'b1;
      mask[idx] = 1'b1;
      if (mask == 4'hF) begin
        hold = {sh[3], sh[2], sh[1], sh[0]};
        exp_q.push_back(hold);
        efv  = 1'b1;
        mask = 4'h0;
      end
    end
    if (efv) since = 0;
    else since++;
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] seg, input bit r);
    @(negedge clk);
    AN = an; seg_data = seg; rst = r;
    @(posedge clk);
    model(an, seg, r);
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    repeat (n) step(an, seg, 1'b0);
  endtask

  task automatic frame(input int d3, input int d2, input int d1, input int d0);
    show(4'b0111, code[d3], 10);
    show(4'b1011, code[d2], 10);
    show(4'b1101, code[d1], 10);
    show(4'b1110, code[d0], 10);
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (mon_en) begin
      chk("frame_valid", 32'(frame_valid), 32'(efv));
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL frame_unexpected: got digits %h expected no frame at %0t",
                   {dig_3, dig_2, dig_1, dig_0}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("frame_digits", 32'({dig_3, dig_2, dig_1, dig_0}), 32'(e));
        end
      end
      chk("held_digits", 32'({dig_3, dig_2, dig_1, dig_0}), 32'(hold));
      chk("bad_seg", 32'(bad_seg), 32'(bad));
      chk("stale", 32'(stale), 32'(since >= T));
    end
  end

  initial begin
    int r, dur;
    logic [3:0] an;
    logic [6:0] seg;
    code = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    for (int i = 0; i < 4; i++) sh[i] = 4'hF;

    step(4'hF, 7'h7F, 1'b1);
    mon_en = 1'b1;
    step(4'hF, 7'h7F, 1'b1);

    frame(1, 2, 3, 4);

    // glitch under digit 0 must not replace the settled value
    show(4'b1110, code[5], 10);
    show(4'b1110, 7'h00, 2);
    show(4'b0111, code[1], 10);
    show(4'b1011, code[2], 10);
    show(4'b1101, code[3], 10);

    show(4'b0011, 7'h40, 20);
    show(4'b1110, code[0], 10);

    show(4'b0111, 7'h7F, 10);
    show(4'b1011, 7'h7E, 10);
    show(4'b1101, code[5], 10);
    show(4'b1110, code[9], 10);
    frame(8, 0, 6, 2);

    step(4'hF, 7'h7F, 1'b1);
    show(4'hF, 7'h7F, 205);
    frame(3, 1, 4, 1);

    show(4'b0111, code[2], 10);
    show(4'b1011, code[7], 10);
    show(4'b1101, code[1], 10);
    step(4'b1101, code[1], 1'b1);
    frame(6, 7, 8, 9);

    repeat (250) begin
      r = $urandom_range(0, 9);
      if (r < 7) an = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) an = 4'hF;
      else if (r == 8) an = ~((4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3)));
      else an = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) seg = code[$urandom_range(0, 9)];
      else if (r == 7) seg = 7'h7F;
      else if (r == 8) seg = 7'h18;
      else seg = 7'($urandom);
      dur = $urandom_range(1, 9);
      if ($urandom_range(0, 59) == 0) step(an, seg, 1'b1);
      show(an, seg, dur);
    end

    show(4'hF, 7'h7F, 5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the stopwatch's multiplexed 7-segment display driver. Monitors the scanned segment bus (seg_data/AN) and rebuilds the four displayed digits as BCD, one full scan frame at a time. Used for on-board loopback self-check and as the bench's display monitor, so display tests compare numbers instead of raw segment patterns. Sits on the same system clock as the display driver, in parallel with the physical pins.

## Interface
- SETTLE_CYCLES, 16: consecutive identical samples required before a digit is captured; minimum 2.
- TIMEOUT_CYCLES, 2000000: cycles without a completed frame before stale asserts; minimum 4.
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- seg_data  input  7  segment bus, active-low; bit0=a, bit1=b, ..., bit6=g.
- AN  input  4  digit anodes, active-low; AN[0] = rightmost digit (digit 0).
- dig_0 .. dig_3  output  4 each  last complete frame, BCD 0-9; 4'hF = blank; 4'hE = unrecognised pattern.
- frame_valid  output  1  one-cycle pulse when dig_0..dig_3 update.
- bad_seg  output  1  sticky: an unrecognised pattern was captured since reset.
- stale  output  1  no frame completed within TIMEOUT_CYCLES.

## Operation
- Input stage: seg_data and AN registered once every cycle (s_seg, s_an); all logic uses the registered copy.
- Stability counter: increments while {s_an, s_seg} equals its value on the previous cycle; saturates at SETTLE_CYCLES. Any change reloads it to 1.
- Anode qualification: only one-hot-low s_an (exactly one bit 0) is capturable. All-high (blanked) or multiple-low (ghost) patterns never capture, still reset the counter on change, and do not touch the shadow digits or mask.
- Capture: on the cycle the counter reaches SETTLE_CYCLES with a qualified anode, decode s_seg into shadow[i] (i = index of the low AN bit) and set mask[i]. Exactly one capture per stable window; a segment change under the same anode opens a new window and overwrites shadow[i].
- Decode (active-low, gfedcba): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10 (also 7'h18 accepted as 9); 7'h7F -> 4'hF; anything else -> 4'hE and bad_seg set.
- Frame: when a capture makes mask = 4'b1111, dig_0..dig_3 load the shadow (including the digit captured that cycle), frame_valid pulses, mask clears. Repeated captures of one digit before the frame completes overwrite only that shadow entry.
- Staleness: counter of cycles since last frame_valid (or since reset), saturating; stale = 1 once it reaches TIMEOUT_CYCLES; cleared in the cycle frame_valid asserts.

## Timing
- Reset (synchronous): dig_0..dig_3 = 4'hF, frame_valid = 0, bad_seg = 0, stale = 0, mask = 0, shadow = 4'hF, stability counter = 0, timeout counter = 0. Reset mid-frame discards partial mask.
- Capture latency: inputs first presented before edge k and held -> sampled at edge k -> shadow written at edge k+SETTLE_CYCLES-1.
- Frame output: dig_* and frame_valid change at the same edge as the completing capture; frame_valid high exactly one cycle; outputs hold between frames.
- Windows shorter than SETTLE_CYCLES samples never capture (glitch/ghost rejection).
- stale rises at edge number TIMEOUT_CYCLES after the last frame_valid (or reset); frame_valid and stale never both 1 in the same cycle.
- bad_seg cleared only by rst.

## Test plan
(SETTLE_CYCLES=4, TIMEOUT_CYCLES=200)
- Scan 1,2,3,4 on AN[3..0] (7'h79,7'h24,7'h30,7'h19), 10 cycles each -> frame_valid one pulse after 4th digit; dig_3=1, dig_2=2, dig_1=3, dig_0=4; bad_seg=0.
- Digit 0 shown 10 cycles, then 2-cycle glitch 7'h00 under AN[0], then remaining digits -> glitch not captured; dig_0 = first captured value.
- AN=4'b0011 (two low) held 20 cycles with 7'h40 -> no capture, mask unchanged, no frame_valid.
- Blank (7'h7F) on digit 3, pattern 7'h7E on digit 2, 5 and 9 on digits 1,0 -> dig_3=F, dig_2=E, dig_1=5, dig_0=9; bad_seg=1 and stays 1 through later clean frames until rst.
- No scan activity for 200 cycles after reset -> stale=1 at cycle 200; one full clean frame -> stale=0 in frame_valid cycle.
- rst asserted after three digits captured, then digits 6,7,8,9 scanned -> only one frame_valid, dig_3..0 = 6,7,8,9; outputs = 4'hF/0 during and after reset cycle.
